// File: rtl/wb_serial_pkg.sv
// Shared constants and state encoding for the byte-stream-to-Wishbone debug bridge.
package wb_serial_pkg;

    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_PING  = 8'h50;

    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        RESP_STAT,
        RESP_DATA
    } state_t;

endpackage

// File: rtl/if_wb.sv
// Single-word 32-bit Wishbone bus bundle shared by the bridge and its slave.
interface if_wb;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;

    modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
    modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);

endinterface

// File: rtl/wb_serial_master.sv
// Debug bridge: parses R/W/P byte commands from a UART, runs one Wishbone
// transaction per command and streams the status/read-data bytes back.
module wb_serial_master
    import wb_serial_pkg::*;
#(
    parameter int TIMEOUT      = 256,
    parameter int IDLE_TIMEOUT = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    if_wb.master        bus,
    output logic        busy,
    output logic        bus_err
);

    localparam int BUS_CW = $clog2(TIMEOUT);
    localparam int GAP_CW = $clog2(IDLE_TIMEOUT);

    state_t              state;
    state_t              state_next;
    logic [1:0]          byte_cnt;
    logic                is_read;
    logic                is_write;
    logic [31:0]         rd_data;
    logic [BUS_CW-1:0]   bus_cnt;
    logic [GAP_CW-1:0]   gap_cnt;

    logic rx_fire;
    logic tx_fire;
    logic last_byte;
    logic bus_expired;
    logic gap_expired;
    logic is_rw_op;

    assign rx_fire     = rx_valid & rx_ready;
    assign tx_fire     = tx_valid & tx_ready;
    assign last_byte   = (byte_cnt == 2'd3);
    assign bus_expired = (bus_cnt == BUS_CW'(TIMEOUT - 1));
    assign gap_expired = !rx_fire && (gap_cnt == GAP_CW'(IDLE_TIMEOUT - 1));
    assign is_rw_op    = (rx_data == OP_READ) || (rx_data == OP_WRITE);

    // NOTE: state_next gets a default before the case so no path through this
    // block leaves it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rx_fire) state_next = is_rw_op ? ADDR : RESP_STAT;
            end
            ADDR: begin
                if (rx_fire && last_byte) state_next = is_write ? DATA : BUS;
                else if (gap_expired)     state_next = IDLE;
            end
            DATA: begin
                if (rx_fire && last_byte) state_next = BUS;
                else if (gap_expired)     state_next = IDLE;
            end
            BUS: begin
                if (bus.ack || bus_expired) state_next = RESP_STAT;
            end
            RESP_STAT: begin
                if (tx_fire) state_next = (is_read && tx_data == RSP_ACK) ? RESP_DATA : IDLE;
            end
            RESP_DATA: begin
                if (tx_fire && last_byte) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every register here is written with <= so all of them update
    // together at the clock edge and read each other's previous values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            rx_ready  <= 1'b1;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            bus_err   <= 1'b0;
            bus.cyc   <= 1'b0;
            bus.stb   <= 1'b0;
            bus.we    <= 1'b0;
            bus.sel   <= 4'h0;
            bus.adr   <= 32'h0;
            bus.dat_w <= 32'h0;
            byte_cnt  <= 2'd0;
            is_read   <= 1'b0;
            is_write  <= 1'b0;
            rd_data   <= 32'h0;
            bus_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            state    <= state_next;
            busy     <= (state_next != IDLE);
            rx_ready <= (state_next inside {IDLE, ADDR, DATA});
            bus_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_fire) begin
                        is_read  <= (rx_data == OP_READ);
                        is_write <= (rx_data == OP_WRITE);
                        byte_cnt <= 2'd0;
                        gap_cnt  <= '0;
                        if (!is_rw_op) begin
                            tx_data  <= (rx_data == OP_PING) ? RSP_ACK : RSP_NAK;
                            tx_valid <= 1'b1;
                        end
                    end
                end
                ADDR, DATA: begin
                    if (rx_fire) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        gap_cnt  <= '0;
                        if (state == ADDR) bus.adr   <= {bus.adr[23:0], rx_data};
                        else               bus.dat_w <= {bus.dat_w[23:0], rx_data};
                    end else begin
                        gap_cnt <= gap_cnt + GAP_CW'(1);
                    end
                end
                BUS: begin
                    // ack takes priority over a timeout landing in the same cycle
                    if (bus.ack || bus_expired) begin
                        bus.cyc  <= 1'b0;
                        bus.stb  <= 1'b0;
                        bus.we   <= 1'b0;
                        bus.sel  <= 4'h0;
                        tx_valid <= 1'b1;
                        if (bus.ack) begin
                            rd_data <= bus.dat_r;
                            tx_data <= RSP_ACK;
                        end else begin
                            bus_err <= 1'b1;
                            tx_data <= RSP_NAK;
                        end
                    end else begin
                        bus_cnt <= bus_cnt + BUS_CW'(1);
                    end
                end
                RESP_STAT: begin
                    if (tx_fire) begin
                        if (is_read && tx_data == RSP_ACK) begin
                            tx_data  <= rd_data[31:24];
                            rd_data  <= {rd_data[23:0], 8'h00};
                            byte_cnt <= 2'd0;
                        end else begin
                            tx_valid <= 1'b0;
                        end
                    end
                end
                RESP_DATA: begin
                    if (tx_fire) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (last_byte) begin
                            tx_valid <= 1'b0;
                        end else begin
                            tx_data <= rd_data[31:24];
                            rd_data <= {rd_data[23:0], 8'h00};
                        end
                    end
                end
                default: ;
            endcase

            if (state_next == BUS && state != BUS) begin
                bus.cyc <= 1'b1;
                bus.stb <= 1'b1;
                bus.sel <= 4'hf;
                bus.we  <= is_write;
                bus_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_serial_master.sv
// Directed bench for wb_serial_master: a command table plus hand-written
// sequences for latency, inter-byte gap, back-pressure and mid-cycle reset.
module tb_wb_serial_master;

    localparam int TIMEOUT      = 16;
    localparam int IDLE_TIMEOUT = 40;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        bus_err;

    if_wb bus ();

    wb_serial_master #(
        .TIMEOUT      (TIMEOUT),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .bus      (bus),
        .busy     (busy),
        .bus_err  (bus_err)
    );

    always #5 clk_i = ~clk_i;

    // Slave: acks once cyc/stb has been high for ack_delay earlier cycles; -1 never acks.
    int          ack_delay;
    logic [31:0] slv_rdata;
    int          slv_cnt;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                   slv_cnt <= 0;
        else if (bus.cyc && bus.stb) slv_cnt <= slv_cnt + 1;
        else                         slv_cnt <= 0;
    end

    assign bus.ack   = bus.cyc && bus.stb && (ack_delay >= 0) && (slv_cnt == ack_delay);
    assign bus.dat_r = slv_rdata;

    // Bus monitor
    logic        mon_clr;
    int          mon_cyc;
    int          mon_err;
    logic [31:0] mon_adr;
    logic [31:0] mon_wdat;
    logic        mon_we;
    logic [3:0]  mon_sel;

    always @(posedge clk_i) begin
        if (mon_clr) begin
            mon_cyc <= 0;
            mon_err <= 0;
        end else begin
            if (bus.cyc) begin
                mon_cyc  <= mon_cyc + 1;
                mon_adr  <= bus.adr;
                mon_wdat <= bus.dat_w;
                mon_we   <= bus.we;
                mon_sel  <= bus.sel;
            end
            if (bus_err) mon_err <= mon_err + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired, got no handshake, expected one", name);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done = 0;
        @(negedge clk_i);
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (rx_ready) begin
                @(posedge clk_i);
                done = 1;
            end else begin
                @(negedge clk_i);
            end
        end
        #1 rx_valid = 1'b0;
        if (!done) bound_fail("send_byte");
    endtask

    task automatic recv_byte(input bit stall, output logic [7:0] b);
        bit          done = 0;
        bit          held = 0;
        logic [7:0]  prev = 8'h00;
        logic        rdy;
        b = 8'hxx;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk_i);
            if (tx_valid) begin
                if (held) check("tx_stable", tx_data, prev);
                rdy      = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                tx_ready = rdy;
                if (rdy) begin
                    b = tx_data;
                    @(posedge clk_i);
                    #1 tx_ready = 1'b0;
                    done = 1;
                end else begin
                    held = 1;
                    prev = tx_data;
                end
            end else begin
                tx_ready = 1'b0;
            end
        end
        if (!done) bound_fail("recv_byte");
    endtask

    task automatic clear_monitor();
        @(negedge clk_i);
        mon_clr = 1'b1;
        @(negedge clk_i);
        mon_clr = 1'b0;
    endtask

    typedef struct {
        string        name;
        logic [71:0]  cmd;       // left-aligned command bytes
        int           n_cmd;
        int           ack_dly;
        logic [31:0]  rdata;
        bit           stall;
        logic [39:0]  rsp;       // left-aligned expected response bytes
        int           n_rsp;
        int           n_cyc;
        logic [31:0]  adr;
        logic [31:0]  wdat;
        logic         we;
        int           n_err;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] b;

    initial begin
        rst_i     = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tx_ready  = 1'b0;
        ack_delay = -1;
        slv_rdata = 32'h0;
        mon_clr   = 1'b1;

        vecs[0] = '{"ping",    {8'h50, 64'h0}, 1, 0, 32'h0, 1'b0,
                    {8'h06, 32'h0}, 1, 0, 32'h0, 32'h0, 1'b0, 0};
        vecs[1] = '{"write",   72'h57_0000_3000_DEAD_BEEF, 9, 3, 32'h0, 1'b0,
                    {8'h06, 32'h0}, 1, 4, 32'h0000_3000, 32'hDEAD_BEEF, 1'b1, 0};
        vecs[2] = '{"read",    {40'h52_0000_3000, 32'h0}, 5, 1, 32'h1234_5678, 1'b0,
                    40'h06_1234_5678, 5, 2, 32'h0000_3000, 32'h0, 1'b0, 0};
        vecs[3] = '{"bad_op",  {8'h41, 64'h0}, 1, 0, 32'h0, 1'b0,
                    {8'h15, 32'h0}, 1, 0, 32'h0, 32'h0, 1'b0, 0};
        vecs[4] = '{"timeout", {40'h52_00D0_0000, 32'h0}, 5, -1, 32'h0, 1'b0,
                    {8'h15, 32'h0}, 1, TIMEOUT, 32'h00D0_0000, 32'h0, 1'b0, 1};
        vecs[5] = '{"rd_stall", {40'h52_8000_0004, 32'h0}, 5, 5, 32'hA5C3_0F81, 1'b1,
                    40'h06_A5C3_0F81, 5, 6, 32'h8000_0004, 32'h0, 1'b0, 0};

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_rx_ready", rx_ready, 1'b1);
        check("rst_tx", {tx_valid, tx_data}, 9'h000);
        check("rst_bus_ctl", {bus.cyc, bus.stb, bus.we, bus.sel}, 7'h00);
        check("rst_bus_adr", bus.adr, 32'h0);
        check("rst_bus_dat", bus.dat_w, 32'h0);
        check("rst_busy_err", {busy, bus_err}, 2'b00);
        rst_i = 1'b0;
        mon_clr = 1'b0;

        for (int v = 0; v < 6; v++) begin
            ack_delay = vecs[v].ack_dly;
            slv_rdata = vecs[v].rdata;
            clear_monitor();
            for (int i = 0; i < vecs[v].n_cmd; i++)
                send_byte(vecs[v].cmd[71 - 8*i -: 8]);
            for (int i = 0; i < vecs[v].n_rsp; i++) begin
                recv_byte(vecs[v].stall, b);
                check({vecs[v].name, "_rsp"}, b, vecs[v].rsp[39 - 8*i -: 8]);
            end
            @(negedge clk_i);
            check({vecs[v].name, "_idle"}, {busy, tx_valid, rx_ready}, 3'b001);
            check({vecs[v].name, "_cyc_cycles"}, mon_cyc, vecs[v].n_cyc);
            check({vecs[v].name, "_bus_err"}, mon_err, vecs[v].n_err);
            if (vecs[v].n_cyc > 0) begin
                check({vecs[v].name, "_adr"}, mon_adr, vecs[v].adr);
                check({vecs[v].name, "_we_sel"}, {mon_we, mon_sel}, {vecs[v].we, 4'hf});
                if (vecs[v].we) check({vecs[v].name, "_wdat"}, mon_wdat, vecs[v].wdat);
            end
        end

        // Latency: cyc one cycle after the last byte; response one cycle after ack
        ack_delay = 2;
        slv_rdata = 32'hCAFE_F00D;
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h40);
        check("lat_cyc_stb", {bus.cyc, bus.stb, rx_ready}, 3'b110);
        begin
            bit seen = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk_i);
                if (bus.ack) seen = 1;
            end
            if (!seen) bound_fail("lat_ack");
        end
        @(posedge clk_i);
        #1 check("lat_resp", {bus.cyc, bus.stb, tx_valid, tx_data}, {3'b001, 8'h06});
        for (int i = 0; i < 5; i++) begin
            recv_byte(1'b0, b);
            check("lat_rsp", b, (40'h06_CAFE_F00D >> (32 - 8*i)) & 40'hFF);
        end

        // Back-pressure: pending status holds off further command bytes
        send_byte(8'h50);
        repeat (4) @(negedge clk_i);
        check("hold_off", {rx_ready, tx_valid, tx_data}, {2'b01, 8'h06});
        recv_byte(1'b0, b);
        check("hold_rsp", b, 8'h06);

        // Inter-byte gap discards a partial command silently
        send_byte(8'h52);
        send_byte(8'h00);
        begin
            bit saw_tx = 0;
            for (int i = 0; i < IDLE_TIMEOUT - 2; i++) begin
                @(negedge clk_i);
                if (tx_valid) saw_tx = 1;
            end
            check("gap_busy_before", busy, 1'b1);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk_i);
                if (tx_valid) saw_tx = 1;
            end
            check("gap_busy_after", {busy, rx_ready}, 2'b01);
            check("gap_no_rsp", saw_tx, 1'b0);
        end
        send_byte(8'h50);
        recv_byte(1'b0, b);
        check("gap_ping", b, 8'h06);

        // Reset in the middle of a bus cycle
        ack_delay = -1;
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        repeat (3) @(negedge clk_i);
        check("mid_cyc_up", bus.cyc, 1'b1);
        #2 rst_i = 1'b1;
        #1 check("mid_rst", {bus.cyc, bus.stb, tx_valid, busy}, 4'b0000);
        @(negedge clk_i);
        rst_i = 1'b0;
        clear_monitor();
        send_byte(8'h50);
        recv_byte(1'b0, b);
        check("post_rst_ping", b, 8'h06);
        check("post_rst_cyc", mon_cyc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "global timeout");
    end

endmodule
